lisnoc_link_arbiter: RTL and testbench
======================================

LISNOC_LINK_ARBITER -- requirements
Module: lisnoc_link_arbiter

Interface
REQ-001 Parameter flit_data_width, default 32, payload bits per flit.
REQ-002 Parameter flit_type_width, default 2, type bits in the flit MSBs; flit_width = flit_data_width + flit_type_width.
REQ-003 Parameter num_ports, default 5, number of requesting input ports (N, E, S, W, local).
REQ-004 Parameter port_width, default 3, width of the port index; must satisfy 2^port_width >= num_ports.
REQ-005 Port clk, input, 1, the block's single clock; all state is updated on its rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous and active-high.
REQ-007 Port req_flit_i, input, num_ports*flit_width, flits from all requesters; port p occupies bits [p*flit_width +: flit_width].
REQ-008 Port req_valid_i, input, num_ports, per-port flit valid.
REQ-009 Port req_ready_o, input-side ready, num_ports, per-port accept; at most one bit is high in any cycle.
REQ-010 Port out_flit_o, output, flit_width, registered output-link flit.
REQ-011 Port out_valid_o, output, 1, registered output-link valid.
REQ-012 Port out_ready_i, input, 1, downstream ready.
REQ-013 Port grant_o, output, num_ports, one-hot index of the port currently holding the wormhole lock; all zero when the block is idle.

Function
REQ-014 Flit type is flit[flit_width-1 -: 2], encoded as follows: HEADER=2'b01, PAYLOAD=2'b00, LAST=2'b10, SINGLE=2'b11.
REQ-015 The output stage is a one-entry register; it can accept a flit (can_accept) when out_valid_o==0 or out_ready_i==1.
REQ-016 A transfer from port p occurs in a cycle exactly when req_valid_i[p]==1 and req_ready_o[p]==1.
REQ-017 The FSM has two states, IDLE and LOCKED, plus a locked-port register lock_port and a round-robin pointer rr_ptr.
REQ-018 In IDLE, the winner is the first port p with req_valid_i[p]==1, searching from rr_ptr upward and wrapping from num_ports-1 to 0.
REQ-019 In IDLE, when can_accept==1, req_ready_o asserts combinationally for the winner only, so a flit is accepted in the same cycle it wins.
REQ-020 In LOCKED, req_ready_o[lock_port] = can_accept; all other ready bits are 0 and their valids are ignored.
REQ-021 When a transferred flit is SINGLE or LAST: next state is IDLE, grant_o becomes 0, and rr_ptr becomes (p+1) wrapping to 0 after num_ports-1.
REQ-022 When a transferred flit is HEADER or PAYLOAD: next state is LOCKED, lock_port becomes p, grant_o[p] becomes 1, and rr_ptr is unchanged.
REQ-023 A flit accepted at edge k appears on out_flit_o/out_valid_o after edge k, giving one cycle of latency and a sustained throughput of 1 flit/cycle when out_ready_i stays high.
REQ-024 The output register holds its value while out_valid_o==1 and out_ready_i==0; out_valid_o clears after an edge where out_ready_i==1 and no transfer occurred.
REQ-025 When the locked port deasserts valid mid-packet, the block inserts a bubble and keeps the lock, with no timeout.
REQ-026 When can_accept==0, all req_ready_o bits are 0 and the FSM state, lock_port and rr_ptr hold.
REQ-027 A PAYLOAD or LAST flit that wins arbitration in IDLE is forwarded as-is, with no error detection: PAYLOAD locks and LAST releases.

Reset
REQ-028 While rst is high: state=IDLE, rr_ptr=0, lock_port=0, grant_o=0, out_valid_o=0, out_flit_o=0.
REQ-029 A reset asserted mid-packet drops the lock and the buffered flit immediately; the remainder of that packet is then treated as new requests.
REQ-030 req_ready_o is 0 while rst is high.

Verification
REQ-031 Reset, then port 2 sends a SINGLE flit 0x3_0000_00AA with out_ready_i=1 -> req_ready_o=5'b00100 in the same cycle; out_flit_o=0x3_0000_00AA with out_valid_o=1 on the next cycle; grant_o stays 0; rr_ptr=3.
REQ-032 Ports 0 and 3 each present a 3-flit packet (HEADER, PAYLOAD, LAST) simultaneously with rr_ptr=0 -> port 0's three flits go out back-to-back, then port 3's three flits; grant_o=5'b00001 during port 0's packet and 5'b01000 during port 3's; the two packets are never interleaved.
REQ-033 Port 4 wins after rr_ptr has wrapped; then ports 0 and 4 both send SINGLE flits -> port 0 is served first (rr_ptr=0 after port 4's release).
REQ-034 Hold out_ready_i=0 for 4 cycles mid-packet -> out_flit_o is stable and req_ready_o=0 throughout; once out_ready_i=1 the packet resumes with no flit lost or duplicated.
REQ-035 Locked port 1 drops valid for 2 cycles while port 2 requests -> port 2 gets no ready and 2 bubbles appear on the output; port 1's LAST flit completes the packet, then port 2 is granted.
REQ-036 Assert rst in the cycle after port 1's HEADER is accepted -> out_valid_o=0 and grant_o=0 immediately; after release, port 1's PAYLOAD wins in IDLE and locks.

Source files
------------

// File: rtl/lisnoc_link_arbiter_if.sv
// lisnoc_link_arbiter_if
//   Bundles the requester side and the output-link side of the link arbiter.
//   Signal names keep the arbiter's point of view (_i = into the arbiter,
//   _o = out of the arbiter).
//
//   req_flit_i  : num_ports*flit_width; port p sits at [p*flit_width +: flit_width]
//   req_valid_i : per-port flit valid
//   req_ready_o : per-port accept, at most one bit high per cycle
//   out_flit_o  : registered output-link flit
//   out_valid_o : registered output-link valid
//   out_ready_i : downstream ready
//   grant_o     : one-hot port holding the wormhole lock, zero when idle
//
//   Modports:
//     slave  - the arbiter itself
//     master - whatever drives the requesters and sinks the output link
interface lisnoc_link_arbiter_if #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int num_ports       = 5
);
  localparam int flit_width = flit_data_width + flit_type_width;

  logic [num_ports*flit_width-1:0] req_flit_i;
  logic [num_ports-1:0]            req_valid_i;
  logic [num_ports-1:0]            req_ready_o;
  logic [flit_width-1:0]           out_flit_o;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [num_ports-1:0]            grant_o;

  modport slave (
    input  req_flit_i,
    input  req_valid_i,
    output req_ready_o,
    output out_flit_o,
    output out_valid_o,
    input  out_ready_i,
    output grant_o
  );

  modport master (
    output req_flit_i,
    output req_valid_i,
    input  req_ready_o,
    input  out_flit_o,
    input  out_valid_o,
    output out_ready_i,
    input  grant_o
  );
endinterface

// File: rtl/lisnoc_link_arbiter.sv
// lisnoc_link_arbiter
//   Wormhole output-link arbiter. Idle ports are arbitrated round-robin; a
//   HEADER or PAYLOAD flit locks the link to its port until a LAST or SINGLE
//   flit releases it. The output link is a one-entry register, so a winning
//   flit is accepted in the cycle it wins and appears one cycle later, with
//   full 1 flit/cycle throughput while the downstream stays ready.
//
//   Ports:
//     clk  - single clock, rising edge
//     rst  - asynchronous active-high reset
//     link - lisnoc_link_arbiter_if.slave (requester flits/valid/ready,
//            output flit/valid/ready, grant)
module lisnoc_link_arbiter #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int num_ports       = 5,
  parameter int port_width      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  lisnoc_link_arbiter_if.slave link
);

  localparam int flit_width = flit_data_width + flit_type_width;

  localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] TYPE_HEADER  = 2'b01;
  localparam logic [1:0] TYPE_LAST    = 2'b10;
  localparam logic [1:0] TYPE_SINGLE  = 2'b11;

  localparam logic [port_width-1:0] LAST_PORT = port_width'(num_ports - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // State
  state_t                  state_q, state_d;
  logic [port_width-1:0]   lock_port_q, lock_port_d;
  logic [port_width-1:0]   rr_ptr_q, rr_ptr_d;
  logic [num_ports-1:0]    grant_q, grant_d;
  logic [flit_width-1:0]   out_flit_q, out_flit_d;
  logic                    out_valid_q, out_valid_d;

  // Per-port views of the flat request bus
  logic [flit_width-1:0]   port_flit [num_ports];
  logic [1:0]              port_type [num_ports];

  genvar gi;
  generate
    for (gi = 0; gi < num_ports; gi++) begin : g_port
      assign port_flit[gi] = link.req_flit_i[gi*flit_width +: flit_width];
      assign port_type[gi] = port_flit[gi][flit_width-1 -: 2];
    end
  endgenerate

  // Round-robin search. Scanning offsets from the highest down lets the
  // closest requester to rr_ptr_q overwrite any farther one, so no break
  // is needed and the loop stays a plain priority mux.
  logic                    win_found;
  logic [port_width-1:0]   win_port;
  int                      scan_idx;
  logic [port_width-1:0]   scan_sel;

  always_comb begin
    win_found = 1'b0;
    win_port  = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int i = num_ports - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= num_ports) begin
        scan_idx = scan_idx - num_ports;
      end
      scan_sel = port_width'(scan_idx);
      if (link.req_valid_i[scan_sel]) begin
        win_found = 1'b1;
        win_port  = scan_sel;
      end
    end
  end

  // Output process: ready generation
  logic                    can_accept;
  logic [num_ports-1:0]    ready;

  always_comb begin
    can_accept = !out_valid_q || link.out_ready_i;
    ready      = '0;
    // Ready is gated by rst directly so nothing is accepted while the
    // asynchronous reset is held, independent of the register contents.
    if (!rst && can_accept) begin
      if (state_q == ST_IDLE) begin
        if (win_found) begin
          ready[win_port] = 1'b1;
        end
      end else begin
        ready[lock_port_q] = 1'b1;
      end
    end
  end

  // Transfer decode
  logic [num_ports-1:0]    xfer_vec;
  logic                    xfer;
  logic [port_width-1:0]   xfer_port;
  logic [flit_width-1:0]   xfer_flit;
  logic [1:0]              xfer_type;
  logic                    xfer_ends_packet;

  assign xfer_vec         = ready & link.req_valid_i;
  assign xfer             = |xfer_vec;
  assign xfer_port        = (state_q == ST_IDLE) ? win_port : lock_port_q;
  assign xfer_flit        = port_flit[xfer_port];
  assign xfer_type        = port_type[xfer_port];
  assign xfer_ends_packet = (xfer_type == TYPE_LAST) || (xfer_type == TYPE_SINGLE);

  // Next-state process
  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      if (xfer_ends_packet) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (xfer_port == LAST_PORT) ? '0 : xfer_port + 1'b1;
      end else begin
        // HEADER or PAYLOAD (even an orphan PAYLOAD winning from idle) locks
        state_d     = ST_LOCKED;
        lock_port_d = xfer_port;
      end
    end
    grant_d = '0;
    if (state_d == ST_LOCKED) begin
      grant_d[lock_port_d] = 1'b1;
    end
  end

  // Output register next values
  always_comb begin
    out_flit_d  = out_flit_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_flit_d  = xfer_flit;
      out_valid_d = 1'b1;
    end else if (link.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_port_q <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign link.req_ready_o = ready;
  assign link.out_flit_o  = out_flit_q;
  assign link.out_valid_o = out_valid_q;
  assign link.grant_o     = grant_q;

endmodule

// File: tb/tb_lisnoc_link_arbiter.sv
// Testbench for lisnoc_link_arbiter: per-port source queues drive packets,
// a reference model predicts ready/grant/valid and the flit order on the
// output link, and a separate monitor pops expected flits as they leave.
module tb_lisnoc_link_arbiter;

  localparam int DW = 32;
  localparam int TW = 2;
  localparam int NP = 5;
  localparam int PW = 3;
  localparam int FW = DW + TW;

  localparam logic [1:0] T_PAY  = 2'b00;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_LAST = 2'b10;
  localparam logic [1:0] T_SGL  = 2'b11;

  typedef logic [FW-1:0] flit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lisnoc_link_arbiter_if #(.flit_data_width(DW), .flit_type_width(TW), .num_ports(NP)) link ();

  lisnoc_link_arbiter #(
    .flit_data_width(DW),
    .flit_type_width(TW),
    .num_ports(NP),
    .port_width(PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .link(link)
  );

  int tests = 0;
  int fails = 0;

  // Sources and scoreboard
  flit_t src_q [NP][$];
  flit_t exp_q [$];
  int    seq = 0;

  // Reference model state: locked port (-1 when idle), round-robin start,
  // and whether the output register holds a flit.
  int    m_lock = -1;
  int    m_rr   = 0;
  bit    m_ov   = 1'b0;

  // Stimulus knobs
  int             valid_prob = 100;
  int             rdy_prob   = 100;
  int             force_rdy  = -1;
  logic [NP-1:0]  en_mask    = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    logic [1:0] t;
    for (int k = 0; k < len; k++) begin
      if (len == 1)           t = T_SGL;
      else if (k == 0)        t = T_HDR;
      else if (k == len - 1)  t = T_LAST;
      else                    t = T_PAY;
      src_q[p].push_back({t, 8'(p), 24'(seq)});
      seq++;
    end
  endtask

  task automatic drive();
    logic [NP-1:0]    v;
    logic [NP*FW-1:0] f;
    for (int p = 0; p < NP; p++) begin
      f[p*FW +: FW] = {2'($urandom_range(3)), 32'($urandom)};
      v[p] = 1'b0;
      if (src_q[p].size() > 0 && en_mask[p] && $urandom_range(99) < valid_prob) begin
        v[p] = 1'b1;
        f[p*FW +: FW] = src_q[p][0];
      end
    end
    link.req_valid_i = v;
    link.req_flit_i  = f;
    if (force_rdy >= 0) link.out_ready_i = (force_rdy == 1);
    else                link.out_ready_i = ($urandom_range(99) < rdy_prob);
  endtask

  // Predict the cycle's behaviour from the arbitration rules, compare the
  // DUT's visible outputs, then advance the model past the coming edge.
  task automatic evaluate();
    logic [NP-1:0] pr;
    logic [NP-1:0] gr;
    bit            can;
    int            win;
    int            q;
    flit_t         fl;
    logic [1:0]    ty;
    can = !m_ov || link.out_ready_i;
    pr  = '0;
    win = -1;
    if (can) begin
      if (m_lock >= 0) begin
        pr[m_lock] = 1'b1;
      end else begin
        for (int i = 0; i < NP; i++) begin
          q = (m_rr + i) % NP;
          if (win < 0 && link.req_valid_i[q]) win = q;
        end
        if (win >= 0) pr[win] = 1'b1;
      end
    end
    gr = '0;
    if (m_lock >= 0) gr[m_lock] = 1'b1;
    check("req_ready", 64'(link.req_ready_o), 64'(pr));
    check("grant", 64'(link.grant_o), 64'(gr));
    check("out_valid", 64'(link.out_valid_o), 64'(m_ov));

    win = -1;
    for (int p = 0; p < NP; p++) if (pr[p] && link.req_valid_i[p]) win = p;
    if (win >= 0) begin
      fl = link.req_flit_i[win*FW +: FW];
      ty = fl[FW-1 -: 2];
      exp_q.push_back(fl);
      if (ty == T_LAST || ty == T_SGL) begin
        m_lock = -1;
        m_rr   = (win + 1) % NP;
      end else begin
        m_lock = win;
      end
      m_ov = 1'b1;
    end else if (link.out_ready_i) begin
      m_ov = 1'b0;
    end

    // Sources follow the DUT's own handshake
    for (int p = 0; p < NP; p++)
      if (link.req_valid_i[p] && link.req_ready_o[p] && src_q[p].size() > 0)
        void'(src_q[p].pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    evaluate();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Reset asserted just after an edge: whatever was accepted at that edge
  // is thrown away along with the lock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive();
    #1;
    check("rst_out_valid", 64'(link.out_valid_o), 64'd0);
    check("rst_grant", 64'(link.grant_o), 64'd0);
    check("rst_out_flit", 64'(link.out_flit_o), 64'd0);
    check("rst_req_ready", 64'(link.req_ready_o), 64'd0);
    m_lock = -1;
    m_rr   = 0;
    m_ov   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    link.req_valid_i = '0;
    rst = 1'b0;
  endtask

  task automatic drain();
    int  guard;
    bit  busy;
    valid_prob = 100;
    rdy_prob   = 100;
    force_rdy  = -1;
    en_mask    = '1;
    guard      = 0;
    busy       = 1'b1;
    while (busy && guard < 500) begin
      step();
      guard++;
      busy = (exp_q.size() > 0) || m_ov;
      for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) busy = 1'b1;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL drain: traffic still pending after %0d cycles", guard);
    end
  endtask

  // Output monitor
  flit_t mon_exp;
  flit_t hold_flit;
  bit    hold_pend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(link.out_valid_o), 64'd1);
        check("hold_flit", 64'(link.out_flit_o), 64'(hold_flit));
      end
      hold_pend = link.out_valid_o && !link.out_ready_i;
      hold_flit = link.out_flit_o;
      if (link.out_valid_o && link.out_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_flit: got %0h expected nothing", link.out_flit_o);
        end else begin
          mon_exp = exp_q.pop_front();
          check("out_flit", 64'(link.out_flit_o), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    link.req_valid_i = '0;
    link.req_flit_i  = '0;
    link.out_ready_i = 1'b0;

    // Single flit from port 2
    do_reset();
    src_q[2].push_back({T_SGL, 32'h0000_00AA});
    run(4);

    // Two 3-flit packets from ports 0 and 3, rr at 0
    do_reset();
    add_pkt(0, 3);
    add_pkt(3, 3);
    run(10);

    // Port 4 alone, then ports 0 and 4 race after the wrap
    do_reset();
    add_pkt(4, 1);
    run(3);
    add_pkt(0, 1);
    add_pkt(4, 1);
    run(5);

    // Downstream stall in the middle of a packet
    add_pkt(1, 6);
    run(2);
    force_rdy = 0;
    run(4);
    force_rdy = -1;
    run(8);

    // Locked port 1 goes quiet for two cycles while port 2 waits
    add_pkt(1, 4);
    add_pkt(2, 1);
    run(2);
    en_mask[1] = 1'b0;
    run(2);
    en_mask = '1;
    run(6);

    // Reset right after port 1's HEADER is accepted
    do_reset();
    add_pkt(1, 3);
    guard = 0;
    while (src_q[1].size() == 3 && guard < 20) begin
      step();
      guard++;
    end
    check("hdr_accept", 64'(src_q[1].size()), 64'd2);
    do_reset();
    drain();

    // Randomized traffic with stalls, gaps and the occasional muted port
    valid_prob = 70;
    rdy_prob   = 75;
    for (int c = 0; c < 3000 && fails < 40; c++) begin
      if ($urandom_range(99) < 40) begin
        int p;
        p = $urandom_range(NP - 1);
        if (src_q[p].size() < 8) add_pkt(p, $urandom_range(1, 4));
      end
      if ($urandom_range(99) < 5) en_mask = NP'($urandom) | NP'(1);
      if ($urandom_range(99) < 10) en_mask = '1;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
